trigger_barrier: RTL and testbench
==================================

Name: trigger_barrier

Overview:
Network-level controller that sits directly upstream of a group of per-actor trigger FSMs. It launches every trigger on a network ap_start and combines each trigger's sleep/sync status into the network-wide all_sleep, all_sync and all_sync_wait barrier signals that every trigger consumes. It latches each trigger's completion and reports network ap_done once every enabled trigger has returned to idle.

Parameters:
NUM_ACTORS, 4, number of trigger instances served (1..64).
ACTOR_MASK, {NUM_ACTORS{1'b1}}, bit i=0 excludes trigger i: never started, treated as permanently sleeping, synced and done.
STATS_WIDTH, 32, width of statistics counters (only used with TRIGGER_BARRIER_STATS_EN).

Ports:
ap_clk  in  1  clock; all logic rising-edge.
ap_rst_n  in  1  synchronous, active-low reset.
ap_start  in  1  network start request.
ap_done  out  1  one-cycle pulse, network run complete.
ap_ready  out  1  equal to ap_done.
ap_idle  out  1  high in IDLE.
actor_ap_start  out  NUM_ACTORS  per-trigger start pulse.
actor_ap_done  in  NUM_ACTORS  per-trigger ap_done (also high whenever the trigger idles without a start).
actor_sleep  in  NUM_ACTORS  per-trigger sleep status.
actor_sync_exec  in  NUM_ACTORS  per-trigger sync_exec status.
actor_sync_wait  in  NUM_ACTORS  per-trigger sync_wait status.
all_sleep  out  1  fan-out to every trigger.
all_sync  out  1  fan-out to every trigger.
all_sync_wait  out  1  fan-out to every trigger.
run_cycles  out  STATS_WIDTH  only with TRIGGER_BARRIER_STATS_EN.
sync_rounds  out  STATS_WIDTH  only with TRIGGER_BARRIER_STATS_EN.

Behaviour:
- Reset (ap_rst_n=0 at an edge): state=IDLE; done_seen=0; stats=0. Outputs: ap_idle=1, ap_done=0, actor_ap_start=0. The barrier outputs stay combinational. Reset in mid-run aborts immediately; no ap_done is issued.
- The FSM has four states: IDLE, START, RUN and DONE.
  - IDLE: when ap_start=1, go to START; otherwise stay in IDLE.
  - START: exactly one cycle. actor_ap_start = ACTOR_MASK. done_seen is cleared. actor_ap_done is ignored in this cycle. Go to RUN.
  - RUN: done_seen <= done_seen | (actor_ap_done & ACTOR_MASK). When (done_seen_next | ~ACTOR_MASK) is all ones, go to DONE.
  - DONE: one cycle. ap_done=ap_ready=1. Go to IDLE. ap_start sampled in DONE is ignored; it is honoured from IDLE on the next cycle.
- actor_ap_start=0 in every state other than START.
- Latency: ap_start sampled in IDLE at cycle t gives actor_ap_start at t+1. If the last done bit arrives at cycle c, ap_done is high at c+1 and ap_idle at c+2.
- Barrier outputs are combinational with zero latency, so every trigger sees identical values in the same cycle:
  - all_sleep = &(actor_sleep | ~ACTOR_MASK)
  - all_sync = &((actor_sync_exec | actor_sync_wait) | ~ACTOR_MASK)
  - all_sync_wait = &(actor_sync_wait | ~ACTOR_MASK)
- Barrier outputs are not gated by FSM state. Idle triggers report sleep and sync_wait, so early-finishing triggers never block the barrier.
- ACTOR_MASK all zero: IDLE, then START (no start bits), then DONE on the first RUN cycle. ap_done appears 3 cycles after ap_start.
- done_seen bits are sticky. A trigger that pulses done and is then restarted externally does not clear its bit.

Optional Feature:
Macro: TRIGGER_BARRIER_STATS_EN.
- Defined: the run_cycles and sync_rounds ports exist.
  - run_cycles is cleared in START and increments every RUN cycle.
  - sync_rounds is cleared in START and increments on each RUN cycle where all_sync=1 and its registered previous value was 0.
  - Both counters saturate at all ones and hold their value through DONE and IDLE until the next START.
- Undefined: the ports and counters are absent, with no other change in behaviour.

Test Plan:
1. Reset with ap_start=1 held: no actor_ap_start while reset is low. After release: ap_idle=1, then actor_ap_start=4'b1111 for exactly 1 cycle.
2. NUM_ACTORS=4: done bits arrive at RUN cycles 3, 7, 7 and 20 -> ap_done high exactly 1 cycle at RUN cycle 21; ap_idle=1 at cycle 22.
3. actor_ap_done=4'b1111 held during the START cycle -> ignored. RUN then latches done in its first cycle, and ap_done follows 1 cycle later.
4. actor_sleep=4'b1011 -> all_sleep=0. Then ACTOR_MASK=4'b1011 with the same input -> all_sleep=1. With sync_exec=4'b0001 and sync_wait=4'b1110 -> all_sync=1, all_sync_wait=0.
5. ACTOR_MASK=0, ap_start pulse -> actor_ap_start stays 0; ap_done 3 cycles after ap_start.
6. With TRIGGER_BARRIER_STATS_EN: a 50-cycle RUN with all_sync rising twice -> run_cycles=50, sync_rounds=2, both held after DONE. Reset asserted mid-RUN -> counters read 0 and no ap_done is issued.

Source files
------------

// File: rtl/trigger_barrier.sv
// Network-level launcher and barrier combiner for a group of trigger FSMs.
// Optional run statistics are enabled with TRIGGER_BARRIER_STATS_EN.
module trigger_barrier #(
    parameter int                    NUM_ACTORS  = 4,
    parameter logic [NUM_ACTORS-1:0] ACTOR_MASK  = {NUM_ACTORS{1'b1}},
    parameter int                    STATS_WIDTH = 32
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ap_start,
    output logic                  ap_done,
    output logic                  ap_ready,
    output logic                  ap_idle,
    output logic [NUM_ACTORS-1:0] actor_ap_start,
    input  logic [NUM_ACTORS-1:0] actor_ap_done,
    input  logic [NUM_ACTORS-1:0] actor_sleep,
    input  logic [NUM_ACTORS-1:0] actor_sync_exec,
    input  logic [NUM_ACTORS-1:0] actor_sync_wait,
    output logic                  all_sleep,
    output logic                  all_sync,
    output logic                  all_sync_wait
`ifdef TRIGGER_BARRIER_STATS_EN
    ,
    output logic [STATS_WIDTH-1:0] run_cycles,
    output logic [STATS_WIDTH-1:0] sync_rounds
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_DONE
    } state_t;

    state_t                  state_reg;
    logic [NUM_ACTORS-1:0]   done_seen_reg;
    logic [NUM_ACTORS-1:0]   done_seen_next;
    logic                    run_complete;
    logic                    ap_done_reg;
    logic                    ap_idle_reg;
    logic [NUM_ACTORS-1:0]   actor_start_reg;

    logic [NUM_ACTORS-1:0]   sleep_ok;
    logic [NUM_ACTORS-1:0]   sync_ok;
    logic [NUM_ACTORS-1:0]   wait_ok;

    if (NUM_ACTORS < 1 || NUM_ACTORS > 64 || STATS_WIDTH < 1) begin : g_param_err
        $error("trigger_barrier: NUM_ACTORS must be 1..64 and STATS_WIDTH >= 1");
    end

    // Excluded triggers always vote "yes" so they can never hold a barrier back.
    genvar gi;
    for (gi = 0; gi < NUM_ACTORS; gi++) begin : g_term
        assign sleep_ok[gi] = actor_sleep[gi] | ~ACTOR_MASK[gi];
        assign sync_ok[gi]  = actor_sync_exec[gi] | actor_sync_wait[gi] | ~ACTOR_MASK[gi];
        assign wait_ok[gi]  = actor_sync_wait[gi] | ~ACTOR_MASK[gi];
    end

    assign all_sleep     = &sleep_ok;
    assign all_sync      = &sync_ok;
    assign all_sync_wait = &wait_ok;

    assign done_seen_next = done_seen_reg | (actor_ap_done & ACTOR_MASK);
    assign run_complete   = &(done_seen_next | ~ACTOR_MASK);

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_reg       <= S_IDLE;
            done_seen_reg   <= '0;
            ap_done_reg     <= 1'b0;
            ap_idle_reg     <= 1'b1;
            actor_start_reg <= '0;
        end else begin
            ap_done_reg     <= 1'b0;
            ap_idle_reg     <= 1'b0;
            actor_start_reg <= '0;
            case (state_reg)
                S_IDLE: begin
                    if (ap_start) begin
                        state_reg       <= S_START;
                        actor_start_reg <= ACTOR_MASK;
                    end else begin
                        ap_idle_reg <= 1'b1;
                    end
                end
                S_START: begin
                    // Completions seen during the launch cycle belong to the previous run.
                    state_reg     <= S_RUN;
                    done_seen_reg <= '0;
                end
                S_RUN: begin
                    done_seen_reg <= done_seen_next;
                    if (run_complete) begin
                        state_reg   <= S_DONE;
                        ap_done_reg <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_reg   <= S_IDLE;
                    ap_idle_reg <= 1'b1;
                end
                default: begin
                    state_reg   <= S_IDLE;
                    ap_idle_reg <= 1'b1;
                end
            endcase
        end
    end

    assign ap_done        = ap_done_reg;
    assign ap_ready       = ap_done_reg;
    assign ap_idle        = ap_idle_reg;
    assign actor_ap_start = actor_start_reg;

`ifdef TRIGGER_BARRIER_STATS_EN
    logic [STATS_WIDTH-1:0] run_cycles_reg;
    logic [STATS_WIDTH-1:0] sync_rounds_reg;
    logic                   all_sync_prev_reg;

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            run_cycles_reg    <= '0;
            sync_rounds_reg   <= '0;
            all_sync_prev_reg <= 1'b0;
        end else begin
            all_sync_prev_reg <= all_sync;
            if (state_reg == S_START) begin
                run_cycles_reg  <= '0;
                sync_rounds_reg <= '0;
            end else if (state_reg == S_RUN) begin
                if (!(&run_cycles_reg))
                    run_cycles_reg <= run_cycles_reg + STATS_WIDTH'(1);
                // A sync round is a rising edge of the network-wide sync barrier.
                if (all_sync && !all_sync_prev_reg && !(&sync_rounds_reg))
                    sync_rounds_reg <= sync_rounds_reg + STATS_WIDTH'(1);
            end
        end
    end

    assign run_cycles  = run_cycles_reg;
    assign sync_rounds = sync_rounds_reg;
`endif

endmodule

// File: tb/tb_trigger_barrier.sv
// Bench for trigger_barrier: three instances (masks 1111, 1011, 0000) share inputs
// and are checked every cycle against a run-level model plus literal spot checks.
module tb_trigger_barrier;

    localparam int          N     = 4;
    localparam int          NDUT  = 3;
    localparam logic [11:0] MASKS = {4'h0, 4'hB, 4'hF};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ap_start;
    logic [N-1:0] a_done, a_sleep, a_sexec, a_swait;

    logic [NDUT-1:0] o_done, o_ready, o_idle, o_sleep, o_sync, o_syncw;
    logic [N-1:0]    o_start [NDUT];
`ifdef TRIGGER_BARRIER_STATS_EN
    logic [31:0]     o_runc  [NDUT];
    logic [31:0]     o_syncr [NDUT];
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        trigger_barrier #(
            .NUM_ACTORS (N),
            .ACTOR_MASK (MASKS[gi*4 +: 4]),
            .STATS_WIDTH(32)
        ) u_dut (
            .ap_clk         (clk),
            .ap_rst_n       (rst_n),
            .ap_start       (ap_start),
            .ap_done        (o_done[gi]),
            .ap_ready       (o_ready[gi]),
            .ap_idle        (o_idle[gi]),
            .actor_ap_start (o_start[gi]),
            .actor_ap_done  (a_done),
            .actor_sleep    (a_sleep),
            .actor_sync_exec(a_sexec),
            .actor_sync_wait(a_swait),
            .all_sleep      (o_sleep[gi]),
            .all_sync       (o_sync[gi]),
            .all_sync_wait  (o_syncw[gi])
`ifdef TRIGGER_BARRIER_STATS_EN
            ,
            .run_cycles     (o_runc[gi]),
            .sync_rounds    (o_syncr[gi])
`endif
        );
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Run-level model: a run is "launch cycle, then run cycles until every enabled
    // trigger has reported done at least once, then one completion cycle".
    bit          m_busy  [NDUT];
    int          m_age   [NDUT];
    logic [N-1:0] m_seen [NDUT];
    bit          m_fin   [NDUT];
    int          m_runc  [NDUT];
    int          m_syncr [NDUT];
    bit          m_prev  [NDUT];

    function automatic logic [N-1:0] mask_of(input int k);
        logic [11:0] all;
        all = MASKS;
        return all[k*4 +: 4];
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            for (int k = 0; k < NDUT; k++) begin
                logic [N-1:0] m;
                bit s;
                m = mask_of(k);
                s = &((a_sexec | a_swait) | ~m);
                if (!rst_n) begin
                    m_busy[k] = 0; m_fin[k] = 0; m_seen[k] = '0;
                    m_runc[k] = 0; m_syncr[k] = 0; s = 0;
                end else if (m_fin[k]) begin
                    m_fin[k] = 0; m_busy[k] = 0;
                end else if (!m_busy[k]) begin
                    if (ap_start) begin m_busy[k] = 1; m_age[k] = 0; end
                end else begin
                    if (m_age[k] == 0) begin
                        m_seen[k] = '0; m_runc[k] = 0; m_syncr[k] = 0;
                    end else begin
                        m_runc[k]++;
                        if (s && !m_prev[k]) m_syncr[k]++;
                        m_seen[k] = m_seen[k] | (a_done & m);
                        if ((m_seen[k] | ~m) == 4'hF) m_fin[k] = 1;
                    end
                    m_age[k]++;
                end
                m_prev[k] = s;
            end
        end
    end

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            for (int k = 0; k < NDUT; k++) begin
                logic [N-1:0] m;
                m = mask_of(k);
                check($sformatf("dut%0d.ap_done", k), 64'(o_done[k]), 64'(m_fin[k]));
                check($sformatf("dut%0d.ap_ready", k), 64'(o_ready[k]), 64'(m_fin[k]));
                check($sformatf("dut%0d.ap_idle", k), 64'(o_idle[k]), 64'(!m_busy[k]));
                check($sformatf("dut%0d.actor_ap_start", k), 64'(o_start[k]),
                      64'((m_busy[k] && m_age[k] == 0) ? m : 4'h0));
                check($sformatf("dut%0d.all_sleep", k), 64'(o_sleep[k]), 64'(&(a_sleep | ~m)));
                check($sformatf("dut%0d.all_sync", k), 64'(o_sync[k]),
                      64'(&((a_sexec | a_swait) | ~m)));
                check($sformatf("dut%0d.all_sync_wait", k), 64'(o_syncw[k]), 64'(&(a_swait | ~m)));
`ifdef TRIGGER_BARRIER_STATS_EN
                check($sformatf("dut%0d.run_cycles", k), 64'(o_runc[k]), 64'(m_runc[k]));
                check($sformatf("dut%0d.sync_rounds", k), 64'(o_syncr[k]), 64'(m_syncr[k]));
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 0; ap_start = 1;
        a_done = '0; a_sleep = '0; a_sexec = '0; a_swait = '0;

        // 1: reset with start held
        repeat (3) begin
            tick();
            check("rst.actor_ap_start", 64'(o_start[0]), 64'h0);
        end
        rst_n = 1;
        check("rst.ap_idle", 64'(o_idle[0]), 64'h1);
        tick();
        check("launch.actor_ap_start", 64'(o_start[0]), 64'hF);
        ap_start = 0;
        tick();
        check("launch.one_cycle", 64'(o_start[0]), 64'h0);
        $display("txn reset/launch done");

        // 2: done bits at RUN cycles 3, 7, 7, 20
        for (int r = 1; r <= 22; r++) begin
            a_done = (r == 3) ? 4'b0001 : (r == 7) ? 4'b0110 : (r == 20) ? 4'b1000 : 4'b0000;
            if (r == 20) check("run.done_c20", 64'(o_done[0]), 64'h0);
            if (r == 21) check("run.done_c21", 64'(o_done[0]), 64'h1);
            if (r == 21) check("run.idle_c21", 64'(o_idle[0]), 64'h0);
            if (r == 22) check("run.idle_c22", 64'(o_idle[0]), 64'h1);
            if (r == 22) check("run.done_c22", 64'(o_done[0]), 64'h0);
            tick();
        end
        $display("txn staggered completion done");

        // 3a: done only during START is ignored
        ap_start = 1; tick();
        ap_start = 0; a_done = 4'hF; tick();
        a_done = 4'h0;
        for (int i = 0; i < 3; i++) begin
            check("start_ignore.no_done", 64'(o_done[0]), 64'h0);
            tick();
        end
        a_done = 4'hF; tick();
        check("start_ignore.done", 64'(o_done[0]), 64'h1);
        a_done = 4'h0; tick();
        // 3b: done held through START and first RUN cycle
        ap_start = 1; tick();
        ap_start = 0; a_done = 4'hF; tick();
        check("held.run1_no_done", 64'(o_done[0]), 64'h0);
        tick();
        check("held.done", 64'(o_done[0]), 64'h1);
        a_done = 4'h0; tick();
        check("held.idle", 64'(o_idle[0]), 64'h1);
        $display("txn start-cycle done handling done");

        // 4: barrier combining
        a_sleep = 4'b1011; #1;
        check("bar.sleep_full", 64'(o_sleep[0]), 64'h0);
        check("bar.sleep_mask1011", 64'(o_sleep[1]), 64'h1);
        check("bar.sleep_mask0", 64'(o_sleep[2]), 64'h1);
        a_sexec = 4'b0001; a_swait = 4'b1110; #1;
        check("bar.sync", 64'(o_sync[0]), 64'h1);
        check("bar.sync_wait", 64'(o_syncw[0]), 64'h0);
        check("bar.sync_wait_m1011", 64'(o_syncw[1]), 64'h0);
        tick();
        a_sleep = 4'hF; a_sexec = 4'b0100; a_swait = 4'b1011; #1;
        check("bar.sleep_all", 64'(o_sleep[0]), 64'h1);
        check("bar.sync_all", 64'(o_sync[0]), 64'h1);
        tick();
        a_sexec = 4'b0100; a_swait = 4'b0011; tick();
        a_sleep = 4'h0; a_sexec = 4'h0; a_swait = 4'h0; tick();
        $display("txn barrier patterns done");

        // 5: empty mask
        ap_start = 1; tick();
        ap_start = 0;
        check("zero.no_start", 64'(o_start[2]), 64'h0);
        tick();
        check("zero.no_done_t2", 64'(o_done[2]), 64'h0);
        tick();
        check("zero.done_t3", 64'(o_done[2]), 64'h1);
        a_done = 4'hF; tick();
        a_done = 4'h0; tick(); tick();
        $display("txn empty mask done");

`ifdef TRIGGER_BARRIER_STATS_EN
        // 6a: 50-cycle run with two sync rounds
        ap_start = 1; tick();
        ap_start = 0; tick();
        for (int r = 1; r <= 50; r++) begin
            a_sexec = ((r >= 5 && r < 10) || (r >= 20 && r < 30)) ? 4'hF : 4'h0;
            a_done  = (r == 50) ? 4'hF : 4'h0;
            tick();
        end
        a_sexec = 4'h0; a_done = 4'h0;
        check("stats.done", 64'(o_done[0]), 64'h1);
        check("stats.run_cycles", 64'(o_runc[0]), 64'd50);
        check("stats.sync_rounds", 64'(o_syncr[0]), 64'd2);
        tick(); tick();
        check("stats.run_cycles_held", 64'(o_runc[0]), 64'd50);
        check("stats.sync_rounds_held", 64'(o_syncr[0]), 64'd2);
        $display("txn stats run done");
`endif

        // 6b: reset mid-run aborts without completion
        ap_start = 1; tick();
        ap_start = 0; tick(); tick(); tick();
        rst_n = 0; tick();
        rst_n = 1;
        check("abort.idle", 64'(o_idle[0]), 64'h1);
`ifdef TRIGGER_BARRIER_STATS_EN
        check("abort.run_cycles", 64'(o_runc[0]), 64'h0);
        check("abort.sync_rounds", 64'(o_syncr[0]), 64'h0);
`endif
        a_done = 4'hF;
        for (int i = 0; i < 4; i++) begin
            check("abort.no_done", 64'(o_done[0]), 64'h0);
            tick();
        end
        a_done = 4'h0; tick();
        $display("txn mid-run reset done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
